// File: rtl/sudoku_grid_checker.sv
// Sudoku entry-and-verify engine for a BOX x BOX-box puzzle: cursor-driven cell entry
// with given-cell protection, then a one-cell-per-clock row/column/box uniqueness scan.
//
// state       | meaning
// S_I         | initial: given cells may be loaded; first button press enters S_SOLVE
// S_SOLVE     | user entry: one cursor move or write per cycle; CheckSolu starts a scan
// S_CHECK     | scanning rows, then columns, then boxes, one cell per clock
// S_CORRECT   | every group holds distinct non-zero values; waits for Ack
// S_INCORRECT | errGroup names the first failing group; waits for Ack
module sudoku_grid_checker #(
  parameter int BOX = 3,
  parameter int VW  = 5,
  parameter int PW  = $clog2(BOX * BOX),
  parameter int GW  = $clog2(3 * BOX * BOX),
  parameter int FW  = $clog2(BOX * BOX * BOX * BOX + 1)
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          R,
  input  logic          L,
  input  logic          U,
  input  logic          D,
  input  logic          C,
  input  logic          CheckSolu,
  input  logic          Ack,
  input  logic [VW-1:0] userIn,
  input  logic          LoadEn,
  input  logic [PW-1:0] LoadRow,
  input  logic [PW-1:0] LoadCol,
  input  logic [VW-1:0] LoadVal,
  output logic          q_I,
  output logic          q_Solve,
  output logic          q_Check,
  output logic          q_Correct,
  output logic          q_Incorrect,
  output logic [PW-1:0] curRow,
  output logic [PW-1:0] curCol,
  output logic [VW-1:0] curVal,
  output logic          curGiven,
  output logic [FW-1:0] filledCnt,
  output logic [GW-1:0] errGroup
);

  localparam int SIDE  = BOX * BOX;
  localparam int CELLS = SIDE * SIDE;
  localparam int IW    = $clog2(CELLS);
  localparam logic [PW-1:0] LAST = PW'(SIDE - 1);

  typedef enum logic [2:0] {S_I, S_SOLVE, S_CHECK, S_CORRECT, S_INCORRECT} state_t;
  state_t state, state_nxt;

  logic [VW-1:0]    grid [CELLS];
  logic [CELLS-1:0] given;

  logic [IW-1:0]   cur_idx, load_idx, scan_idx, wr_idx;
  logic            any_btn, act_ok, start_chk, coord_ok, load_ok;
  logic            do_c, do_r, do_l, do_u, do_d;
  logic            wr_en, wr_given;
  logic [VW-1:0]   wr_val, wr_old, scan_val;
  logic [1:0]      grp_type;
  logic [PW-1:0]   grp_idx, pos, scan_row, scan_col;
  logic [SIDE-1:0] mask, eff_mask, val_bit;
  logic            scan_fail, scan_last;

  assign cur_idx  = IW'(curRow) * IW'(SIDE) + IW'(curCol);
  assign load_idx = IW'(LoadRow) * IW'(SIDE) + IW'(LoadCol);
  assign curVal   = grid[cur_idx];
  assign curGiven = given[cur_idx];

  // Only non-power-of-two sides can present an off-grid load coordinate.
  generate
    if ((1 << PW) == SIDE) begin : g_pow2
      assign coord_ok = 1'b1;
    end else begin : g_npow2
      assign coord_ok = (LoadRow < PW'(SIDE)) && (LoadCol < PW'(SIDE));
    end
  endgenerate

  assign any_btn   = R | L | U | D | C;
  assign start_chk = (state == S_SOLVE) && CheckSolu;
  assign act_ok    = (state == S_I) || ((state == S_SOLVE) && !CheckSolu);
  assign do_c      = act_ok & C;
  assign do_r      = act_ok & ~C & R;
  assign do_l      = act_ok & ~C & ~R & L;
  assign do_u      = act_ok & ~C & ~R & ~L & U;
  assign do_d      = act_ok & ~C & ~R & ~L & ~U & D;
  assign load_ok   = (state == S_I) && LoadEn && coord_ok &&
                     (LoadVal != '0) && (LoadVal <= VW'(SIDE));

  always_comb begin
    wr_en    = 1'b0;
    wr_idx   = cur_idx;
    wr_val   = userIn;
    wr_given = 1'b0;
    if (load_ok) begin
      wr_en    = 1'b1;
      wr_idx   = load_idx;
      wr_val   = LoadVal;
      wr_given = 1'b1;
    end else if (do_c && !given[cur_idx] && (userIn <= VW'(SIDE))) begin
      wr_en = 1'b1;
    end
  end

  assign wr_old = grid[wr_idx];

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      for (int i = 0; i < CELLS; i++) grid[i] <= '0;
      given     <= '0;
      curRow    <= '0;
      curCol    <= '0;
      filledCnt <= '0;
    end else begin
      if (wr_en) begin
        grid[wr_idx] <= wr_val;
        if (wr_given) given[wr_idx] <= 1'b1;
        if (wr_old == '0 && wr_val != '0)      filledCnt <= filledCnt + FW'(1);
        else if (wr_old != '0 && wr_val == '0) filledCnt <= filledCnt - FW'(1);
      end
      if (do_r) curCol <= (curCol == LAST) ? '0 : curCol + PW'(1);
      if (do_l) curCol <= (curCol == '0) ? LAST : curCol - PW'(1);
      if (do_u) curRow <= (curRow == '0) ? LAST : curRow - PW'(1);
      if (do_d) curRow <= (curRow == LAST) ? '0 : curRow + PW'(1);
    end
  end

  // grp_type: 0 = rows, 1 = columns, 2 = boxes; pos walks the cells of one group.
  always_comb begin
    scan_row = grp_idx;
    scan_col = pos;
    case (grp_type)
      2'd1: begin
        scan_row = pos;
        scan_col = grp_idx;
      end
      2'd2: begin
        scan_row = PW'((int'(grp_idx) / BOX) * BOX + int'(pos) / BOX);
        scan_col = PW'((int'(grp_idx) % BOX) * BOX + int'(pos) % BOX);
      end
      default: ;
    endcase
  end

  assign scan_idx = IW'(scan_row) * IW'(SIDE) + IW'(scan_col);
  assign scan_val = grid[scan_idx];

  always_comb begin
    val_bit = '0;
    for (int i = 0; i < SIDE; i++) val_bit[i] = (scan_val == VW'(i + 1));
  end

  assign eff_mask  = (pos == '0) ? '0 : mask;
  assign scan_fail = (scan_val == '0) || (|(eff_mask & val_bit));
  assign scan_last = (grp_type == 2'd2) && (grp_idx == LAST) && (pos == LAST);

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      grp_type <= '0;
      grp_idx  <= '0;
      pos      <= '0;
      mask     <= '0;
      errGroup <= '0;
    end else if (start_chk) begin
      grp_type <= '0;
      grp_idx  <= '0;
      pos      <= '0;
      mask     <= '0;
    end else if (state == S_CHECK) begin
      if (scan_fail) errGroup <= GW'(int'(grp_type) * SIDE + int'(grp_idx));
      mask <= eff_mask | val_bit;
      if (pos == LAST) begin
        pos <= '0;
        if (grp_idx == LAST) begin
          grp_idx  <= '0;
          grp_type <= grp_type + 2'd1;
        end else begin
          grp_idx <= grp_idx + PW'(1);
        end
      end else begin
        pos <= pos + PW'(1);
      end
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) state <= S_I;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_I:         if (any_btn) state_nxt = S_SOLVE;
      S_SOLVE:     if (CheckSolu) state_nxt = S_CHECK;
      S_CHECK: begin
        if (scan_fail)      state_nxt = S_INCORRECT;
        else if (scan_last) state_nxt = S_CORRECT;
      end
      S_CORRECT,
      S_INCORRECT: if (Ack) state_nxt = S_SOLVE;
      default:     state_nxt = S_I;
    endcase
  end

  always_comb begin
    q_I         = 1'b0;
    q_Solve     = 1'b0;
    q_Check     = 1'b0;
    q_Correct   = 1'b0;
    q_Incorrect = 1'b0;
    case (state)
      S_I:         q_I         = 1'b1;
      S_SOLVE:     q_Solve     = 1'b1;
      S_CHECK:     q_Check     = 1'b1;
      S_CORRECT:   q_Correct   = 1'b1;
      S_INCORRECT: q_Incorrect = 1'b1;
      default:     q_I         = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_sudoku_grid_checker.sv
// Scoreboarded bench: a 4x4 instance driven by directed and random button sessions against
// a grid-level model, plus a 9x9 instance exercising reset during a check.
module tb_sudoku_grid_checker;
  localparam int BOX = 2;
  localparam int S   = BOX * BOX;
  localparam int VW  = 5;
  localparam int PW  = 2;
  localparam int GW  = 4;
  localparam int FW  = 5;

  // one-hot codes in the order {q_I, q_Solve, q_Check, q_Correct, q_Incorrect}
  localparam int ST_I = 16, ST_SOLVE = 8, ST_CHECK = 4, ST_CORRECT = 2, ST_INCORRECT = 1;

  logic Clk = 1'b0;
  logic Reset = 1'b1;
  logic R = 0, L = 0, U = 0, D = 0, C = 0, CheckSolu = 0, Ack = 0, LoadEn = 0;
  logic [VW-1:0] userIn = '0, LoadVal = '0;
  logic [PW-1:0] LoadRow = '0, LoadCol = '0;
  logic q_I, q_Solve, q_Check, q_Correct, q_Incorrect;
  logic [PW-1:0] curRow, curCol;
  logic [VW-1:0] curVal;
  logic curGiven;
  logic [FW-1:0] filledCnt;
  logic [GW-1:0] errGroup;

  logic rst3 = 1'b1, r3 = 0, c3 = 0, chk3 = 0, ld3 = 0, zero3 = 0;
  logic [VW-1:0] uin3 = '0, lval3 = '0;
  logic [3:0] lrow3 = '0, lcol3 = '0;
  logic q3_i, q3_solve, q3_check, q3_correct, q3_incorrect;
  logic [3:0] row3, col3;
  logic [VW-1:0] val3;
  logic given3;
  logic [6:0] filled3;
  logic [4:0] err3;

  sudoku_grid_checker #(.BOX(2), .VW(VW)) dut (
    .Clk(Clk), .Reset(Reset), .R(R), .L(L), .U(U), .D(D), .C(C),
    .CheckSolu(CheckSolu), .Ack(Ack), .userIn(userIn), .LoadEn(LoadEn),
    .LoadRow(LoadRow), .LoadCol(LoadCol), .LoadVal(LoadVal),
    .q_I(q_I), .q_Solve(q_Solve), .q_Check(q_Check), .q_Correct(q_Correct),
    .q_Incorrect(q_Incorrect), .curRow(curRow), .curCol(curCol), .curVal(curVal),
    .curGiven(curGiven), .filledCnt(filledCnt), .errGroup(errGroup)
  );

  sudoku_grid_checker #(.BOX(3), .VW(VW)) dut3 (
    .Clk(Clk), .Reset(rst3), .R(r3), .L(zero3), .U(zero3), .D(zero3), .C(c3),
    .CheckSolu(chk3), .Ack(zero3), .userIn(uin3), .LoadEn(ld3),
    .LoadRow(lrow3), .LoadCol(lcol3), .LoadVal(lval3),
    .q_I(q3_i), .q_Solve(q3_solve), .q_Check(q3_check), .q_Correct(q3_correct),
    .q_Incorrect(q3_incorrect), .curRow(row3), .curCol(col3), .curVal(val3),
    .curGiven(given3), .filledCnt(filled3), .errGroup(err3)
  );

  always #5 Clk = ~Clk;

  typedef struct {int st; int row; int col; int val; int given; int filled; int err;} snap_t;
  typedef struct {int st; int cycles; int err;} res_t;
  snap_t snap_q[$];
  res_t  res_q[$];

  int checks = 0;
  int errors = 0;

  function automatic void check(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // grid-level reference model
  int m_grid[S][S];
  bit m_given[S][S];
  int m_row, m_col, m_state, m_err;

  function automatic int m_filled();
    int n = 0;
    for (int r = 0; r < S; r++)
      for (int c = 0; c < S; c++)
        if (m_grid[r][c] != 0) n++;
    return n;
  endfunction

  // Walks the 3*S groups in scan order; kf is the flat step index of the first bad cell.
  function automatic void m_check(output bit ok, output int kf);
    bit [S:0] seen;
    int r, c, v, b;
    ok = 1;
    kf = 0;
    for (int g = 0; g < 3 * S && ok; g++) begin
      seen = '0;
      for (int p = 0; p < S && ok; p++) begin
        if (g < S) begin
          r = g; c = p;
        end else if (g < 2 * S) begin
          r = p; c = g - S;
        end else begin
          b = g - 2 * S;
          r = (b / BOX) * BOX + p / BOX;
          c = (b % BOX) * BOX + p % BOX;
        end
        v = m_grid[r][c];
        if (v == 0 || seen[v]) begin
          ok = 0;
          kf = g * S + p;
        end else begin
          seen[v] = 1'b1;
        end
      end
    end
  endfunction

  function automatic void m_action(bit r, bit l, bit u, bit d, bit c, int uin, bit can_write);
    if (c) begin
      if (can_write && !m_given[m_row][m_col] && uin <= S) m_grid[m_row][m_col] = uin;
    end else if (r) m_col = (m_col + 1) % S;
    else if (l)     m_col = (m_col + S - 1) % S;
    else if (u)     m_row = (m_row + S - 1) % S;
    else if (d)     m_row = (m_row + 1) % S;
  endfunction

  function automatic void model_step(bit r, bit l, bit u, bit d, bit c, bit chk, bit ack,
                                     bit ld, int uin, int lr, int lc, int lv);
    snap_t s;
    res_t  rs;
    bit ok;
    int kf;
    bit do_chk = 0;
    bit loaded = 0;
    if (m_state == ST_I) begin
      if (ld && lv >= 1 && lv <= S) begin
        m_grid[lr][lc]  = lv;
        m_given[lr][lc] = 1;
        loaded = 1;
      end
      if (r | l | u | d | c) begin
        m_action(r, l, u, d, c, uin, !loaded);
        m_state = ST_SOLVE;
      end
    end else if (m_state == ST_SOLVE) begin
      if (chk) begin
        do_chk  = 1;
        m_state = ST_CHECK;
      end else begin
        m_action(r, l, u, d, c, uin, 1);
      end
    end else if (m_state == ST_CORRECT || m_state == ST_INCORRECT) begin
      if (ack) m_state = ST_SOLVE;
    end
    s.st = m_state; s.row = m_row; s.col = m_col;
    s.val = m_grid[m_row][m_col]; s.given = m_given[m_row][m_col];
    s.filled = m_filled(); s.err = m_err;
    snap_q.push_back(s);
    if (do_chk) begin
      m_check(ok, kf);
      if (ok) begin
        rs.st = ST_CORRECT; rs.cycles = 3 * S * S; rs.err = m_err;
        m_state = ST_CORRECT;
      end else begin
        m_err = kf / S;
        rs.st = ST_INCORRECT; rs.cycles = kf + 1; rs.err = m_err;
        m_state = ST_INCORRECT;
      end
      res_q.push_back(rs);
    end
  endfunction

  // monitor: one snapshot per input transaction, one result per completed check
  logic  mon_txn;
  logic  prev_check = 1'b0;
  int    chk_cycles = 0;
  snap_t mon_s;
  res_t  mon_r;

  always @(posedge Clk) begin
    mon_txn = R | L | U | D | C | CheckSolu | Ack | LoadEn;
    #1;
    if (mon_txn) begin
      if (snap_q.size() == 0) begin
        check("snap_underflow", 0, 1);
      end else begin
        mon_s = snap_q.pop_front();
        check("state", int'({q_I, q_Solve, q_Check, q_Correct, q_Incorrect}), mon_s.st);
        check("curRow", int'(curRow), mon_s.row);
        check("curCol", int'(curCol), mon_s.col);
        check("curVal", int'(curVal), mon_s.val);
        check("curGiven", int'(curGiven), mon_s.given);
        check("filledCnt", int'(filledCnt), mon_s.filled);
        check("errGroup_hold", int'(errGroup), mon_s.err);
      end
    end
    if (q_Check) chk_cycles++;
    if ((q_Correct || q_Incorrect) && prev_check) begin
      if (res_q.size() == 0) begin
        check("result_underflow", 0, 1);
      end else begin
        mon_r = res_q.pop_front();
        check("result_state", int'({q_I, q_Solve, q_Check, q_Correct, q_Incorrect}), mon_r.st);
        check("check_cycles", chk_cycles, mon_r.cycles);
        check("errGroup", int'(errGroup), mon_r.err);
      end
      chk_cycles = 0;
    end
    prev_check = q_Check;
  end

  task automatic txn(input bit r, l, u, d, c, chk, ack, ld,
                     input int uin = 0, input int lr = 0, input int lc = 0, input int lv = 0);
    @(negedge Clk);
    R = r; L = l; U = u; D = d; C = c; CheckSolu = chk; Ack = ack; LoadEn = ld;
    userIn = VW'(uin); LoadRow = PW'(lr); LoadCol = PW'(lc); LoadVal = VW'(lv);
    model_step(r, l, u, d, c, chk, ack, ld, uin, lr, lc, lv);
    @(negedge Clk);
    R = 0; L = 0; U = 0; D = 0; C = 0; CheckSolu = 0; Ack = 0; LoadEn = 0;
  endtask

  task automatic mv_r(); txn(1, 0, 0, 0, 0, 0, 0, 0); endtask
  task automatic mv_l(); txn(0, 1, 0, 0, 0, 0, 0, 0); endtask
  task automatic mv_u(); txn(0, 0, 1, 0, 0, 0, 0, 0); endtask
  task automatic mv_d(); txn(0, 0, 0, 1, 0, 0, 0, 0); endtask
  task automatic commit(input int v); txn(0, 0, 0, 0, 1, 0, 0, 0, v); endtask
  task automatic load(input int r, input int c, input int v); txn(0, 0, 0, 0, 0, 0, 0, 1, 0, r, c, v); endtask
  task automatic ack(); txn(0, 0, 0, 0, 0, 0, 1, 0); endtask

  task automatic wait_result();
    int n = 0;
    while (!(q_Correct || q_Incorrect) && n < 200) begin
      @(negedge Clk);
      n++;
    end
    check("result_seen", int'(q_Correct || q_Incorrect), 1);
  endtask

  task automatic do_check();
    txn(0, 0, 0, 0, 0, 1, 0, 0);
    wait_result();
  endtask

  int sol[S][S] = '{'{1, 2, 3, 4}, '{3, 4, 1, 2}, '{2, 1, 4, 3}, '{4, 3, 2, 1}};
  int sel;
  logic [4:0] bits;

  initial begin
    for (int r = 0; r < S; r++)
      for (int c = 0; c < S; c++) begin
        m_grid[r][c] = 0;
        m_given[r][c] = 0;
      end
    m_row = 0; m_col = 0; m_state = ST_I; m_err = 0;

    repeat (2) @(negedge Clk);
    check("rst_state", int'({q_I, q_Solve, q_Check, q_Correct, q_Incorrect}), ST_I);
    check("rst_row", int'(curRow), 0);
    check("rst_col", int'(curCol), 0);
    check("rst_filled", int'(filledCnt), 0);
    check("rst_err", int'(errGroup), 0);
    check("rst_val", int'(curVal), 0);
    Reset = 0;
    rst3  = 0;

    // givens, invalid loads, cursor wrap
    load(1, 1, 4);
    load(2, 2, 5);
    load(3, 3, 0);
    mv_l(); mv_u(); mv_r();
    mv_d(); mv_d(); mv_r();
    commit(2);
    mv_r();
    commit(7);
    mv_u(); mv_l(); mv_l();

    // full valid solution
    for (int r = 0; r < S; r++) begin
      for (int c = 0; c < S; c++) begin
        commit(sol[r][c]);
        mv_r();
      end
      mv_d();
    end
    do_check();
    ack();

    // duplicate in row 0
    mv_r();
    commit(1);
    do_check();
    ack();

    // simultaneous C+R writes only; erase; CheckSolu beats C; inputs ignored in result
    txn(1, 0, 0, 0, 1, 0, 0, 0, 2);
    commit(0);
    txn(0, 0, 0, 0, 1, 1, 0, 0, 3);
    wait_result();
    txn(1, 1, 1, 1, 1, 1, 0, 1, 3, 0, 0, 2);
    txn(1, 0, 0, 0, 0, 0, 1, 0);

    // random sessions
    for (int i = 0; i < 220; i++) begin
      sel = $urandom_range(0, 15);
      if (sel == 0) begin
        bits = 5'($urandom_range(0, 31));
        txn(bits[0], bits[1], bits[2], bits[3], bits[4], 1, 0, 0, $urandom_range(0, 6));
        wait_result();
        if ($urandom_range(0, 1) == 1) begin
          bits = 5'($urandom_range(1, 31));
          txn(bits[0], bits[1], bits[2], bits[3], bits[4], 1, 0, 1, $urandom_range(0, 4), 0, 0, 1);
        end
        bits = 5'($urandom_range(0, 31));
        txn(bits[0], bits[1], bits[2], bits[3], bits[4], 0, 1, 0, $urandom_range(0, 4));
      end else begin
        bits = 5'($urandom_range(1, 31));
        txn(bits[0], bits[1], bits[2], bits[3], bits[4], 0, 1'($urandom_range(0, 1)), 0,
            $urandom_range(0, 6));
      end
    end

    // 9x9: reset while checking, then the undisturbed empty-grid check
    @(negedge Clk);
    ld3 = 1; lrow3 = 4'd8; lcol3 = 4'd8; lval3 = 5'd5;
    @(negedge Clk);
    ld3 = 0;
    check("b3_load_filled", int'(filled3), 1);
    r3 = 1;
    @(negedge Clk);
    r3 = 0;
    check("b3_solve", int'(q3_solve), 1);
    check("b3_col", int'(col3), 1);
    chk3 = 1;
    @(negedge Clk);
    chk3 = 0;
    check("b3_in_check", int'(q3_check), 1);
    #1 rst3 = 1;
    #1;
    check("b3_rst_state", int'({q3_i, q3_solve, q3_check, q3_correct, q3_incorrect}), ST_I);
    check("b3_rst_row", int'(row3), 0);
    check("b3_rst_col", int'(col3), 0);
    check("b3_rst_filled", int'(filled3), 0);
    @(negedge Clk);
    rst3 = 0;
    c3 = 1; uin3 = '0;
    @(negedge Clk);
    c3 = 0;
    check("b3_solve2", int'(q3_solve), 1);
    chk3 = 1;
    @(negedge Clk);
    chk3 = 0;
    check("b3_check2", int'(q3_check), 1);
    @(negedge Clk);
    check("b3_incorrect", int'(q3_incorrect), 1);
    check("b3_err", int'(err3), 0);

    repeat (2) @(negedge Clk);
    check("snap_q_drained", snap_q.size(), 0);
    check("res_q_drained", res_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, %0d checks, %0d errors", checks, errors);
    $fatal(1);
  end

endmodule
